// File: rtl/wr_pps_monitor_if.sv
// wr_pps_monitor_if
//   Bundles the PPS monitor's data-path signals so that the monitor and its
//   driver share a single port. clk/reset stay as plain ports on the monitor.
//   master : the side that drives pps_i, tm_tai_i, clear_i and snap_i, and
//            reads back the counters.
//   slave  : the monitor itself.
//   Signals:
//     pps_i          PPS level (synchronous to the system clock)
//     tm_tai_i       current TAI seconds
//     clear_i        synchronous clear of the pps/clk/err counters
//     snap_i         snapshot request
//     pps_count_o    PPS rising edges seen (wraps)
//     clk_count_o    free-running cycle count (wraps)
//     period_o       last scored PPS-to-PPS period in cycles
//     period_valid_o period_o holds at least one scored measurement
//     tai_at_pps_o   TAI seconds latched at the last PPS edge
//     locked_o       enough consecutive good periods seen
//     missing_o      PPS timed out since the last edge
//     err_count_o    bad periods plus timeouts (saturates)
//     snap_*_o       snapshot of pps/clk/err counters
//     snap_valid_o   one-cycle pulse when the snapshot registers update
interface wr_pps_monitor_if #(
    parameter int CNT_WIDTH = 32,
    parameter int TAI_WIDTH = 10
);
    logic                 pps_i;
    logic [TAI_WIDTH-1:0] tm_tai_i;
    logic                 clear_i;
    logic                 snap_i;
    logic [CNT_WIDTH-1:0] pps_count_o;
    logic [CNT_WIDTH-1:0] clk_count_o;
    logic [CNT_WIDTH-1:0] period_o;
    logic                 period_valid_o;
    logic [TAI_WIDTH-1:0] tai_at_pps_o;
    logic                 locked_o;
    logic                 missing_o;
    logic [CNT_WIDTH-1:0] err_count_o;
    logic [CNT_WIDTH-1:0] snap_pps_o;
    logic [CNT_WIDTH-1:0] snap_clk_o;
    logic [CNT_WIDTH-1:0] snap_err_o;
    logic                 snap_valid_o;

    modport master (
        output pps_i, tm_tai_i, clear_i, snap_i,
        input  pps_count_o, clk_count_o, period_o, period_valid_o,
               tai_at_pps_o, locked_o, missing_o, err_count_o,
               snap_pps_o, snap_clk_o, snap_err_o, snap_valid_o
    );

    modport slave (
        input  pps_i, tm_tai_i, clear_i, snap_i,
        output pps_count_o, clk_count_o, period_o, period_valid_o,
               tai_at_pps_o, locked_o, missing_o, err_count_o,
               snap_pps_o, snap_clk_o, snap_err_o, snap_valid_o
    );
endinterface

// File: rtl/wr_pps_monitor.sv
// wr_pps_monitor
//   PPS and system-clock health monitor. Counts PPS rising edges and clock
//   cycles, measures every PPS-to-PPS period, declares lock after LOCK_COUNT
//   consecutive good periods, flags a missing PPS on timeout, accumulates
//   errors, latches TAI seconds at each PPS, and offers an atomic
//   snapshot / clear for software readout.
//   Ports:
//     clk_sys_i  system clock, all logic on its rising edge
//     reset_n_i  asynchronous active-low reset
//     mon        wr_pps_monitor_if.slave (inputs pps/tai/clear/snap, all
//                registered status and counter outputs)
module wr_pps_monitor #(
    parameter int CNT_WIDTH       = 32,
    parameter int TAI_WIDTH       = 10,
    parameter int EXPECTED_CYCLES = 62500000,
    parameter int TOLERANCE       = 16,
    parameter int LOCK_COUNT      = 4
) (
    input  logic              clk_sys_i,
    input  logic              reset_n_i,
    wr_pps_monitor_if.slave   mon
);

    localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
    localparam int LO_INT = (EXPECTED_CYCLES > TOLERANCE) ? (EXPECTED_CYCLES - TOLERANCE) : 0;

    // Good-period window compared one bit wider than the counters so the
    // bounds can never alias around the counter width.
    localparam logic [CNT_WIDTH:0]   LO_LIM      = (CNT_WIDTH+1)'(LO_INT);
    localparam logic [CNT_WIDTH:0]   HI_LIM      = (CNT_WIDTH+1)'(EXPECTED_CYCLES + TOLERANCE);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(EXPECTED_CYCLES + TOLERANCE + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
    localparam logic [RUN_W-1:0]     RUN_FULL    = RUN_W'(LOCK_COUNT);

    typedef enum logic {ARMED = 1'b0, TRACK = 1'b1} state_t;

    state_t               state_reg, state_next;
    logic                 pps_d_reg;
    logic [CNT_WIDTH-1:0] ival_reg;
    logic [RUN_W-1:0]     run_reg;
    logic [CNT_WIDTH-1:0] pps_count_reg, clk_count_reg, err_count_reg, period_reg;
    logic [CNT_WIDTH-1:0] snap_pps_reg, snap_clk_reg, snap_err_reg;
    logic [TAI_WIDTH-1:0] tai_reg;
    logic                 period_valid_reg, locked_reg, missing_reg, snap_valid_reg;

    logic                 pps_edge, timeout_hit, period_good;
    logic                 score, timeout, err_inc;
    logic [RUN_W-1:0]     run_inc;

    assign pps_edge    = mon.pps_i & ~pps_d_reg;
    assign timeout_hit = (ival_reg == TIMEOUT_VAL);
    assign period_good = ({1'b0, ival_reg} >= LO_LIM) && ({1'b0, ival_reg} <= HI_LIM);
    assign run_inc     = (run_reg == RUN_FULL) ? run_reg : run_reg + RUN_W'(1);
    assign err_inc     = (score & ~period_good) | timeout;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg <= ARMED;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    // An edge always wins over a coincident timeout.
    always_comb begin
        state_next = state_reg;
        if (pps_edge) begin
            state_next = TRACK;
        end else if (timeout_hit) begin
            state_next = ARMED;
        end
    end

    // ---------------- FSM: decoded actions ----------------
    // Only edges seen while tracking have a reference edge, so only those
    // are scored; the first edge after ARMED just re-establishes one.
    always_comb begin
        score   = 1'b0;
        timeout = 1'b0;
        if (pps_edge) begin
            score = (state_reg == TRACK);
        end else begin
            timeout = timeout_hit;
        end
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pps_d_reg        <= 1'b0;
            ival_reg         <= '0;
            run_reg          <= '0;
            pps_count_reg    <= '0;
            clk_count_reg    <= '0;
            err_count_reg    <= '0;
            period_reg       <= '0;
            period_valid_reg <= 1'b0;
            tai_reg          <= '0;
            locked_reg       <= 1'b0;
            missing_reg      <= 1'b0;
            snap_pps_reg     <= '0;
            snap_clk_reg     <= '0;
            snap_err_reg     <= '0;
            snap_valid_reg   <= 1'b0;
        end else begin
            pps_d_reg <= mon.pps_i;

            // Loading 1 on the edge makes ival read exactly t1-t0 at the next edge.
            if (pps_edge) begin
                ival_reg <= CNT_ONE;
            end else if (ival_reg != CNT_MAX) begin
                ival_reg <= ival_reg + CNT_ONE;
            end

            if (pps_edge) begin
                tai_reg     <= mon.tm_tai_i;
                missing_reg <= 1'b0;
            end

            if (score) begin
                period_reg       <= ival_reg;
                period_valid_reg <= 1'b1;
                if (period_good) begin
                    run_reg    <= run_inc;
                    locked_reg <= (run_inc == RUN_FULL);
                end else begin
                    run_reg    <= '0;
                    locked_reg <= 1'b0;
                end
            end

            if (timeout) begin
                missing_reg <= 1'b1;
                run_reg     <= '0;
                locked_reg  <= 1'b0;
            end

            // Clear takes priority over any same-cycle increment.
            if (mon.clear_i) begin
                pps_count_reg <= '0;
                clk_count_reg <= '0;
                err_count_reg <= '0;
            end else begin
                clk_count_reg <= clk_count_reg + CNT_ONE;
                if (pps_edge) begin
                    pps_count_reg <= pps_count_reg + CNT_ONE;
                end
                if (err_inc && (err_count_reg != CNT_MAX)) begin
                    err_count_reg <= err_count_reg + CNT_ONE;
                end
            end

            // Snapshot sees the pre-update, pre-clear values, so snap+clear
            // in one cycle is an atomic read-and-clear.
            snap_valid_reg <= mon.snap_i;
            if (mon.snap_i) begin
                snap_pps_reg <= pps_count_reg;
                snap_clk_reg <= clk_count_reg;
                snap_err_reg <= err_count_reg;
            end
        end
    end

    assign mon.pps_count_o    = pps_count_reg;
    assign mon.clk_count_o    = clk_count_reg;
    assign mon.period_o       = period_reg;
    assign mon.period_valid_o = period_valid_reg;
    assign mon.tai_at_pps_o   = tai_reg;
    assign mon.locked_o       = locked_reg;
    assign mon.missing_o      = missing_reg;
    assign mon.err_count_o    = err_count_reg;
    assign mon.snap_pps_o     = snap_pps_reg;
    assign mon.snap_clk_o     = snap_clk_reg;
    assign mon.snap_err_o     = snap_err_reg;
    assign mon.snap_valid_o   = snap_valid_reg;

endmodule

// File: tb/tb_wr_pps_monitor.sv
module tb_wr_pps_monitor;

    localparam int CW   = 16;
    localparam int SW   = 8;
    localparam int TW   = 10;
    localparam int EXP  = 100;
    localparam int TOL  = 2;
    localparam int LOCK = 3;
    localparam longint CNT_MAX = (64'd1 << CW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wr_pps_monitor_if #(.CNT_WIDTH(CW), .TAI_WIDTH(TW)) mon ();
    wr_pps_monitor_if #(.CNT_WIDTH(SW), .TAI_WIDTH(TW)) mon_s ();

    wr_pps_monitor #(.CNT_WIDTH(CW), .TAI_WIDTH(TW), .EXPECTED_CYCLES(EXP),
                     .TOLERANCE(TOL), .LOCK_COUNT(LOCK)) dut (
        .clk_sys_i (clk),
        .reset_n_i (rst_n),
        .mon       (mon)
    );

    // Narrow-counter instance so wrap and saturation are reachable quickly.
    wr_pps_monitor #(.CNT_WIDTH(SW), .TAI_WIDTH(TW), .EXPECTED_CYCLES(EXP),
                     .TOLERANCE(TOL), .LOCK_COUNT(LOCK)) dut_s (
        .clk_sys_i (clk),
        .reset_n_i (rst_n),
        .mon       (mon_s)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    int tb_cyc = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- Reference model (timestamp based) ----------------
    longint m_cyc, m_t0;
    bit     m_tracking, m_pps_prev;
    int     m_run;
    longint e_pps, e_clk, e_err, e_period, e_tai;
    longint e_snap_pps, e_snap_clk, e_snap_err;
    bit     e_pv, e_locked, e_missing, e_snap_valid;

    always @(posedge clk or negedge rst_n) begin : model
        longint gap;
        bit     rise;
        bit     good;
        bit     bump_err;
        if (!rst_n) begin
            m_cyc = 0; m_t0 = 0; m_tracking = 0; m_pps_prev = 0; m_run = 0;
            e_pps = 0; e_clk = 0; e_err = 0; e_period = 0; e_tai = 0;
            e_snap_pps = 0; e_snap_clk = 0; e_snap_err = 0;
            e_pv = 0; e_locked = 0; e_missing = 0; e_snap_valid = 0;
        end else begin
            rise       = mon.pps_i && !m_pps_prev;
            m_pps_prev = mon.pps_i;
            gap        = m_cyc - m_t0;
            if (gap > CNT_MAX) gap = CNT_MAX;
            bump_err   = 0;
            if (mon.snap_i) begin
                e_snap_pps = e_pps; e_snap_clk = e_clk; e_snap_err = e_err;
            end
            e_snap_valid = mon.snap_i;
            e_clk = (e_clk + 1) % (CNT_MAX + 1);
            if (rise) begin
                e_pps = (e_pps + 1) % (CNT_MAX + 1);
                e_tai = mon.tm_tai_i;
                if (m_tracking) begin
                    e_period = gap;
                    e_pv     = 1;
                    good     = (gap >= EXP - TOL) && (gap <= EXP + TOL);
                    if (good) m_run = (m_run + 1 > LOCK) ? LOCK : m_run + 1;
                    else begin m_run = 0; bump_err = 1; end
                end
                m_tracking = 1;
                e_missing  = 0;
                m_t0       = m_cyc;
            end else if (gap == EXP + TOL + 1) begin
                e_missing  = 1;
                bump_err   = 1;
                m_run      = 0;
                m_tracking = 0;
            end
            if (bump_err && e_err < CNT_MAX) e_err++;
            e_locked = (m_run == LOCK);
            if (mon.clear_i) begin
                e_pps = 0; e_clk = 0; e_err = 0;
            end
            m_cyc++;
        end
    end

    // ---------------- Per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            chk("pps_count",    mon.pps_count_o,    e_pps);
            chk("clk_count",    mon.clk_count_o,    e_clk);
            chk("err_count",    mon.err_count_o,    e_err);
            chk("period",       mon.period_o,       e_period);
            chk("period_valid", mon.period_valid_o, e_pv);
            chk("tai_at_pps",   mon.tai_at_pps_o,   e_tai);
            chk("locked",       mon.locked_o,       e_locked);
            chk("missing",      mon.missing_o,      e_missing);
            chk("snap_pps",     mon.snap_pps_o,     e_snap_pps);
            chk("snap_clk",     mon.snap_clk_o,     e_snap_clk);
            chk("snap_err",     mon.snap_err_o,     e_snap_err);
            chk("snap_valid",   mon.snap_valid_o,   e_snap_valid);
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic tick_t(input bit p, input bit s, input bit c, input logic [TW-1:0] tai);
        mon.pps_i    = p;
        mon.snap_i   = s;
        mon.clear_i  = c;
        mon.tm_tai_i = tai;
        @(posedge clk);
        #1;
        tb_cyc++;
    endtask

    task automatic tick(input bit p, input bit s, input bit c);
        tick_t(p, s, c, TW'($urandom));
    endtask

    task automatic idle_to(input int t);
        while (tb_cyc < t) tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse(input int width);
        repeat (width) tick(1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mon.pps_i = 0; mon.snap_i = 0; mon.clear_i = 0; mon.tm_tai_i = '0;
        mon_s.pps_i = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pps",    mon.pps_count_o,  0);
        chk("reset_clk",    mon.clk_count_o,  0);
        chk("reset_locked", mon.locked_o,     0);
        rst_n  = 1'b1;
        tb_cyc = 0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ival, width;
        mon_s.pps_i = 0; mon_s.snap_i = 0; mon_s.clear_i = 0; mon_s.tm_tai_i = '0;
        do_reset();
        cmp_en = 1'b1;

        // Regular 1-cycle PPS, lock after three good periods
        idle_to(10);  pulse(1);
        chk("s1_first_unscored", mon.period_valid_o, 0);
        chk("s1_pps1",           mon.pps_count_o,    1);
        idle_to(110); pulse(1);
        chk("s1_period",         mon.period_o,       100);
        chk("s1_pvalid",         mon.period_valid_o, 1);
        idle_to(210); pulse(1);
        idle_to(310);
        chk("s1_not_locked_yet", mon.locked_o,       0);
        pulse(1);
        chk("s1_locked",         mon.locked_o,       1);
        chk("s1_pps4",           mon.pps_count_o,    4);
        chk("s1_err0",           mon.err_count_o,    0);

        // PPS stops: timeout one cycle after ival reaches 103
        idle_to(413);
        chk("s4_missing_before", mon.missing_o,      0);
        tick(1'b0, 1'b0, 1'b0);
        chk("s4_missing",        mon.missing_o,      1);
        chk("s4_err1",           mon.err_count_o,    1);
        chk("s4_unlock",         mon.locked_o,       0);
        idle_to(500); pulse(1);
        chk("s4_missing_clr",    mon.missing_o,      0);
        chk("s4_period_kept",    mon.period_o,       100);
        idle_to(600); pulse(1);
        chk("s4_scored",         mon.period_o,       100);
        idle_to(703); pulse(1);
        chk("s4_edge_at_thr",    mon.period_o,       103);
        chk("s4_err2",           mon.err_count_o,    2);
        chk("s4_no_missing",     mon.missing_o,      0);

        // Wide pulses count once each
        idle_to(803);  pulse(5);
        chk("s2_pps8",           mon.pps_count_o,    8);
        idle_to(903);  pulse(5);
        chk("s2_pps9",           mon.pps_count_o,    9);
        idle_to(1003); pulse(5);
        chk("s2_pps10",          mon.pps_count_o,    10);
        chk("s2_period",         mon.period_o,       100);
        chk("s2_locked",         mon.locked_o,       1);

        // Bad short period breaks lock, next good one does not restore it
        idle_to(1100); pulse(1);
        chk("s3_err3",           mon.err_count_o,    3);
        chk("s3_unlock",         mon.locked_o,       0);
        chk("s3_period97",       mon.period_o,       97);
        idle_to(1198); pulse(1);
        chk("s3_period98",       mon.period_o,       98);
        chk("s3_still_unlock",   mon.locked_o,       0);
        chk("s3_err_same",       mon.err_count_o,    3);

        // snap + clear + edge in one cycle
        idle_to(1298);
        tick_t(1'b1, 1'b1, 1'b1, 10'h2A5);
        chk("s5_snap_pps",       mon.snap_pps_o,     12);
        chk("s5_snap_clk",       mon.snap_clk_o,     1298);
        chk("s5_snap_err",       mon.snap_err_o,     3);
        chk("s5_snap_valid",     mon.snap_valid_o,   1);
        chk("s5_pps_cleared",    mon.pps_count_o,    0);
        chk("s5_clk_cleared",    mon.clk_count_o,    0);
        chk("s5_tai",            mon.tai_at_pps_o,   10'h2A5);
        tick(1'b0, 1'b0, 1'b0);
        chk("s5_snap_pulse_end", mon.snap_valid_o,   0);
        chk("s5_snap_hold",      mon.snap_pps_o,     12);

        // Randomised PPS, snapshots and clears against the model
        for (int seg = 0; seg < 40; seg++) begin
            ival  = ($urandom_range(0, 4) == 0) ? $urandom_range(104, 140)
                                                 : $urandom_range(96, 104);
            width = $urandom_range(1, 4);
            for (int k = 0; k < ival; k++)
                tick(k < width, $urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0);
        end

        // Asynchronous reset mid-interval
        idle_to(tb_cyc + 37);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_pps",    mon.pps_count_o,    0);
        chk("areset_clk",    mon.clk_count_o,    0);
        chk("areset_err",    mon.err_count_o,    0);
        chk("areset_period", mon.period_o,       0);
        chk("areset_snap",   mon.snap_pps_o,     0);
        chk("areset_s_clk",  mon_s.clk_count_o,  0);
        do_reset();
        idle_to(5); pulse(1);
        chk("areset_first_unscored", mon.period_valid_o, 0);

        // Narrow instance: clk wrap and err saturation
        do_reset();
        for (int i = 0; i < 600; i++) begin
            mon_s.pps_i = (tb_cyc % 2 == 0);
            tick(1'b0, 1'b0, 1'b0);
            if (tb_cyc == 255) chk("s6_clk_ff",  mon_s.clk_count_o, 8'hFF);
            if (tb_cyc == 256) begin
                chk("s6_clk_wrap", mon_s.clk_count_o, 0);
                chk("s6_err127",   mon_s.err_count_o, 127);
            end
            if (tb_cyc == 520) chk("s6_err_sat",  mon_s.err_count_o, 8'hFF);
        end
        chk("s6_err_hold", mon_s.err_count_o, 8'hFF);
        chk("s6_clk_88",   mon_s.clk_count_o, 88);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
